// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Reset sequencer. Synchronises the release of CDN, releases
//               four active-low domain resets in order with a fixed gap,
//               and supports a timed soft reset and a test-mode bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int STAGE_GAP     = 4,
    parameter int SW_RST_CYCLES = 8
) (
    input  logic       CP,
    input  logic       CDN,
    input  logic       sw_rst_req,
    input  logic       test_mode,
    output logic [3:0] rstn_out,
    output logic       rst_busy,
    output logic       sw_rst_ack
);

    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int HOLD_W = $clog2(SW_RST_CYCLES + 1);

    localparam logic [GAP_W-1:0]  c_GAP_LOAD  = GAP_W'(STAGE_GAP - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = HOLD_W'(SW_RST_CYCLES - 1);
    localparam logic [GAP_W-1:0]  c_GAP_ONE   = GAP_W'(1);
    localparam logic [HOLD_W-1:0] c_HOLD_ONE  = HOLD_W'(1);

    localparam logic [1:0] c_ASSERT  = 2'd0;
    localparam logic [1:0] c_RELEASE = 2'd1;
    localparam logic [1:0] c_RUN     = 2'd2;
    localparam logic [1:0] c_SWRST   = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [3:0]             r_rstn;
    logic                   r_ack;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   w_sync_rstn;

    assign w_sync_rstn = r_sync[SYNC_STAGES-1];

    // Counters are loaded with N-1 so the next event lands exactly N edges later.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            r_sync     <= '0;
            r_state    <= c_ASSERT;
            r_rstn     <= 4'b0000;
            r_ack      <= 1'b0;
            r_gap_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            r_ack  <= 1'b0;
            case (r_state)
                c_ASSERT: begin
                    if (w_sync_rstn) begin
                        r_state   <= c_RELEASE;
                        r_rstn    <= 4'b0001;
                        r_gap_cnt <= c_GAP_LOAD;
                    end
                end
                c_RELEASE: begin
                    if (r_gap_cnt == '0) begin
                        r_rstn    <= {r_rstn[2:0], 1'b1};
                        r_gap_cnt <= c_GAP_LOAD;
                        if (r_rstn[2]) begin
                            r_state <= c_RUN;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
                    end
                end
                c_RUN: begin
                    if (sw_rst_req) begin
                        r_state    <= c_SWRST;
                        r_rstn     <= 4'b0000;
                        r_ack      <= 1'b1;
                        r_hold_cnt <= c_HOLD_LOAD;
                    end
                end
                c_SWRST: begin
                    if (r_hold_cnt == '0) begin
                        r_state   <= c_RELEASE;
                        r_rstn    <= 4'b0001;
                        r_gap_cnt <= c_GAP_LOAD;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;
                    end
                end
                default: begin
                    r_state <= c_ASSERT;
                    r_rstn  <= 4'b0000;
                end
            endcase
        end
    end

    // Test mode bypasses the sequencer combinationally; the FSM keeps running.
    assign rstn_out   = test_mode ? {4{CDN}} : r_rstn;
    assign rst_busy   = test_mode ? ~CDN : ~(&r_rstn);
    assign sw_rst_ack = test_mode ? 1'b0 : r_ack;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Directed self-checking bench for rst_seq_ctrl (default and
//               SYNC_STAGES=3 / STAGE_GAP=1 instances share CP and CDN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

    logic       CP = 1'b0;
    logic       CDN = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       sw_rst_req_b = 1'b0;
    logic       test_mode = 1'b0;
    logic [3:0] rstn_a, rstn_b;
    logic       busy_a, busy_b, ack_a, ack_b;

    int n_vec = 0;
    int n_err = 0;

    rst_seq_ctrl u_dut_a (
        .CP         (CP),
        .CDN        (CDN),
        .sw_rst_req (sw_rst_req),
        .test_mode  (test_mode),
        .rstn_out   (rstn_a),
        .rst_busy   (busy_a),
        .sw_rst_ack (ack_a)
    );

    rst_seq_ctrl #(.SYNC_STAGES(3), .STAGE_GAP(1), .SW_RST_CYCLES(8)) u_dut_b (
        .CP         (CP),
        .CDN        (CDN),
        .sw_rst_req (sw_rst_req_b),
        .test_mode  (test_mode),
        .rstn_out   (rstn_b),
        .rst_busy   (busy_b),
        .sw_rst_ack (ack_b)
    );

    always #5 CP = ~CP;

    // Expected rstn_out n edges after the start of a sequence whose first
    // release lands at edge s+1 and whose later releases are g edges apart.
    function automatic logic [3:0] exp_rstn(input int n, input int s, input int g);
        int k;
        if (n < s + 1) return 4'b0000;
        k = (n - s - 1) / g + 1;
        if (k > 4) k = 4;
        return 4'((1 << k) - 1);
    endfunction

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        CDN = 1'b0; test_mode = 1'b0; sw_rst_req = 1'b0;
        repeat (5) tick();
        n_vec++; if (rstn_a !== 4'b0000) begin n_err++; $display("FAIL reset_rstn_a: got %b want 0000", rstn_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL reset_busy_a: got %b want 1", busy_a); end
        n_vec++; if (ack_a !== 1'b0) begin n_err++; $display("FAIL reset_ack_a: got %b want 0", ack_a); end
        n_vec++; if (rstn_b !== 4'b0000) begin n_err++; $display("FAIL reset_rstn_b: got %b want 0000", rstn_b); end
        n_vec++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL reset_busy_b: got %b want 1", busy_b); end
    endtask

    task automatic test_power_up();
        logic [3:0] ea, eb;
        CDN = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            ea = exp_rstn(n, 2, 4);
            eb = exp_rstn(n, 3, 1);
            n_vec++; if (rstn_a !== ea) begin n_err++; $display("FAIL pwr_rstn_a edge %0d: got %b want %b", n, rstn_a, ea); end
            n_vec++; if (busy_a !== (ea != 4'hf)) begin n_err++; $display("FAIL pwr_busy_a edge %0d: got %b want %b", n, busy_a, (ea != 4'hf)); end
            n_vec++; if (ack_a !== 1'b0) begin n_err++; $display("FAIL pwr_ack_a edge %0d: got %b want 0", n, ack_a); end
            n_vec++; if (rstn_b !== eb) begin n_err++; $display("FAIL pwr_rstn_b edge %0d: got %b want %b", n, rstn_b, eb); end
        end
    endtask

    task automatic test_soft_reset();
        logic [3:0] e;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        n_vec++; if (rstn_a !== 4'b0000) begin n_err++; $display("FAIL sw_rstn_a edge E: got %b want 0000", rstn_a); end
        n_vec++; if (ack_a !== 1'b1) begin n_err++; $display("FAIL sw_ack_a edge E: got %b want 1", ack_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL sw_busy_a edge E: got %b want 1", busy_a); end
        n_vec++; if (rstn_b !== 4'hf) begin n_err++; $display("FAIL sw_rstn_b edge E: got %b want 1111", rstn_b); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = exp_rstn(k, 7, 4);
            n_vec++; if (rstn_a !== e) begin n_err++; $display("FAIL sw_rstn_a edge E+%0d: got %b want %b", k, rstn_a, e); end
            n_vec++; if (ack_a !== 1'b0) begin n_err++; $display("FAIL sw_ack_a edge E+%0d: got %b want 0", k, ack_a); end
        end
    endtask

    // Request held across the power-up; accepted on the first edge sampled in RUN.
    task automatic test_ignored_req();
        logic [3:0] e;
        logic       eack;
        CDN = 1'b0;
        repeat (3) tick();
        CDN = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            tick();
            e    = (n <= 15) ? exp_rstn(n, 2, 4) : exp_rstn(n - 16, 7, 4);
            eack = (n == 16);
            n_vec++; if (rstn_a !== e) begin n_err++; $display("FAIL ign_rstn_a edge %0d: got %b want %b", n, rstn_a, e); end
            n_vec++; if (ack_a !== eack) begin n_err++; $display("FAIL ign_ack_a edge %0d: got %b want %b", n, ack_a, eack); end
            if (n == 3)  sw_rst_req = 1'b1;
            if (n == 20) sw_rst_req = 1'b0;
        end
    endtask

    task automatic test_abort();
        logic [3:0] ea, eb;
        CDN = 1'b0;
        repeat (2) tick();
        CDN = 1'b1;
        repeat (9) tick();
        n_vec++; if (rstn_a !== 4'b0011) begin n_err++; $display("FAIL abort_pre_rstn_a: got %b want 0011", rstn_a); end
        #1 CDN = 1'b0;
        #1;
        n_vec++; if (rstn_a !== 4'b0000) begin n_err++; $display("FAIL abort_rstn_a: got %b want 0000", rstn_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL abort_busy_a: got %b want 1", busy_a); end
        n_vec++; if (rstn_b !== 4'b0000) begin n_err++; $display("FAIL abort_rstn_b: got %b want 0000", rstn_b); end
        #2 CDN = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            ea = exp_rstn(n, 2, 4);
            eb = exp_rstn(n, 3, 1);
            n_vec++; if (rstn_a !== ea) begin n_err++; $display("FAIL abort_rstn_a edge %0d: got %b want %b", n, rstn_a, ea); end
            n_vec++; if (rstn_b !== eb) begin n_err++; $display("FAIL abort_rstn_b edge %0d: got %b want %b", n, rstn_b, eb); end
        end
        // Abort in the middle of a soft-reset hold.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        repeat (3) tick();
        #1 CDN = 1'b0;
        #2 CDN = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            ea = exp_rstn(n, 2, 4);
            n_vec++; if (rstn_a !== ea) begin n_err++; $display("FAIL abort_sw_rstn_a edge %0d: got %b want %b", n, rstn_a, ea); end
        end
    endtask

    task automatic test_test_mode();
        test_mode = 1'b1;
        #1;
        n_vec++; if (rstn_a !== 4'hf) begin n_err++; $display("FAIL tm_hi_rstn_a: got %b want 1111", rstn_a); end
        CDN = 1'b0;
        #1;
        n_vec++; if (rstn_a !== 4'h0) begin n_err++; $display("FAIL tm_lo_rstn_a: got %b want 0000", rstn_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL tm_lo_busy_a: got %b want 1", busy_a); end
        n_vec++; if (rstn_b !== 4'h0) begin n_err++; $display("FAIL tm_lo_rstn_b: got %b want 0000", rstn_b); end
        CDN = 1'b1;
        #1;
        n_vec++; if (rstn_a !== 4'hf) begin n_err++; $display("FAIL tm_rise_rstn_a: got %b want 1111", rstn_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL tm_rise_busy_a: got %b want 0", busy_a); end
        for (int n = 1; n <= 9; n++) begin
            tick();
            n_vec++; if (rstn_a !== 4'hf) begin n_err++; $display("FAIL tm_rstn_a edge %0d: got %b want 1111", n, rstn_a); end
            n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL tm_busy_a edge %0d: got %b want 0", n, busy_a); end
        end
        test_mode = 1'b0;
        #1;
        n_vec++; if (rstn_a !== 4'b0011) begin n_err++; $display("FAIL tm_exit_rstn_a: got %b want 0011", rstn_a); end
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL tm_exit_busy_a: got %b want 1", busy_a); end
        n_vec++; if (rstn_b !== 4'b1111) begin n_err++; $display("FAIL tm_exit_rstn_b: got %b want 1111", rstn_b); end
        repeat (6) tick();
        n_vec++; if (rstn_a !== 4'hf) begin n_err++; $display("FAIL tm_run_rstn_a: got %b want 1111", rstn_a); end
        // Soft reset accepted internally while the bypass masks the ack.
        test_mode  = 1'b1;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        n_vec++; if (ack_a !== 1'b0) begin n_err++; $display("FAIL tm_sw_ack_a: got %b want 0", ack_a); end
        n_vec++; if (rstn_a !== 4'hf) begin n_err++; $display("FAIL tm_sw_rstn_a: got %b want 1111", rstn_a); end
        test_mode = 1'b0;
        #1;
        n_vec++; if (ack_a !== 1'b1) begin n_err++; $display("FAIL tm_sw_int_ack_a: got %b want 1", ack_a); end
        n_vec++; if (rstn_a !== 4'h0) begin n_err++; $display("FAIL tm_sw_int_rstn_a: got %b want 0000", rstn_a); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_power_up();
        test_soft_reset();
        test_ignored_req();
        test_abort();
        test_test_mode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
